// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Frame controller that sits behind a UART receiver. It turns the receiver's
// byte stream into frames of the form HEADER, CMD, LEN, PAYLOAD[LEN], CSUM.
// A complete frame with a good checksum is held until the host acknowledges it.
// The payload is read through a registered read port.
// Malformed frames are reported with a one-cycle error pulse and an error code.
// Optional feature: define UART_FRAME_TIMEOUT_EN to enable the inter-byte
// timeout (err_code 2). Without it, a partial frame may stall forever.

module uart_rx_frame_ctrl #(
  parameter int          CLK_FREQ      = 50000000,
  parameter int          BAUD_RATE     = 115200,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter int          MAX_LEN       = 16,
  parameter int          TIMEOUT_BYTES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_data_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_frame_valid,
  output logic [7:0] o_frame_cmd,
  output logic [4:0] o_frame_len,
  input  logic       i_frame_ack,
  input  logic [3:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic       o_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    PAYLOAD,
    CSUM,
    HOLD
  } FrameState;

  localparam logic [1:0] ERR_LENGTH   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;
  localparam logic [7:0] MAX_LEN_B    = 8'(MAX_LEN);

  FrameState   r_state;
  FrameState   w_stateNext;

  logic        r_validD;
  logic        w_accept;

  logic [7:0]  r_frameCmd;
  logic [4:0]  r_frameLen;
  logic [4:0]  w_lenMinus1;
  logic [7:0]  r_csum;
  logic [3:0]  r_idx;
  logic [7:0]  r_buf [0:15];
  logic [7:0]  r_rdData;

  logic        r_frameErr;
  logic [1:0]  r_errCode;
  logic        r_overrun;

  logic        w_errPulse;
  logic [1:0]  w_errCodeNext;
  logic        w_overrunPulse;
  logic        w_loadCmd;
  logic        w_loadLen;
  logic        w_loadPay;
  logic        w_inFrame;
  logic        w_timeoutHit;

  // The receiver may hold valid high for many cycles, so only the rising edge
  // of rx_data_valid counts as a new byte.
  assign w_accept    = i_rx_data_valid & ~r_validD;
  assign w_lenMinus1 = r_frameLen - 5'd1;
  assign w_inFrame   = (r_state == CMD) || (r_state == LEN) ||
                       (r_state == PAYLOAD) || (r_state == CSUM);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam logic [23:0] TO_LIMIT =
    24'((CLK_FREQ / BAUD_RATE) * 10 * TIMEOUT_BYTES);

  logic [23:0] r_toCount;

  // Count idle cycles while inside a frame; every accepted byte restarts it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_toCount <= 24'd0;
    end else if (!w_inFrame || w_accept) begin
      r_toCount <= 24'd0;
    end else begin
      r_toCount <= r_toCount + 24'd1;
    end
  end

  // An accept in the same cycle as the limit wins over the timeout.
  assign w_timeoutHit = w_inFrame && !w_accept && (r_toCount == TO_LIMIT - 24'd1);
`else
  assign w_timeoutHit = 1'b0;
`endif

  // State register; a reset discards any partial frame silently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Framing sequence: next state plus the load strobes and error/overrun pulses.
  always_comb begin
    w_stateNext    = r_state;
    w_errPulse     = 1'b0;
    w_errCodeNext  = 2'd0;
    w_overrunPulse = 1'b0;
    w_loadCmd      = 1'b0;
    w_loadLen      = 1'b0;
    w_loadPay      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_accept && (i_rx_data == HEADER)) begin
          w_stateNext = CMD;
        end
      end

      CMD: begin
        if (w_accept) begin
          w_loadCmd   = 1'b1;
          w_stateNext = LEN;
        end
      end

      LEN: begin
        if (w_accept) begin
          if (i_rx_data > MAX_LEN_B) begin
            w_errPulse    = 1'b1;
            w_errCodeNext = ERR_LENGTH;
            w_stateNext   = IDLE;
          end else begin
            w_loadLen   = 1'b1;
            w_stateNext = (i_rx_data == 8'd0) ? CSUM : PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (w_accept) begin
          w_loadPay = 1'b1;
          if ({1'b0, r_idx} == w_lenMinus1) begin
            w_stateNext = CSUM;
          end
        end
      end

      CSUM: begin
        if (w_accept) begin
          if (i_rx_data == r_csum) begin
            w_stateNext = HOLD;
          end else begin
            w_errPulse    = 1'b1;
            w_errCodeNext = ERR_CHECKSUM;
            w_stateNext   = IDLE;
          end
        end
      end

      HOLD: begin
        // The host ack wins over a byte arriving in the same cycle.
        if (i_frame_ack) begin
          w_stateNext = IDLE;
        end else if (w_accept && (i_rx_data == HEADER)) begin
          w_overrunPulse = 1'b1;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase

    if (w_timeoutHit) begin
      w_errPulse    = 1'b1;
      w_errCodeNext = ERR_TIMEOUT;
      w_stateNext   = IDLE;
    end
  end

  // Previous valid level, used for edge detection of incoming bytes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_validD <= 1'b0;
    end else begin
      r_validD <= i_rx_data_valid;
    end
  end

  // Frame header fields, running checksum and payload index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frameCmd <= 8'd0;
      r_frameLen <= 5'd0;
      r_csum     <= 8'd0;
      r_idx      <= 4'd0;
    end else begin
      if (w_loadCmd) begin
        r_frameCmd <= i_rx_data;
        r_csum     <= i_rx_data;
      end
      if (w_loadLen) begin
        r_frameLen <= i_rx_data[4:0];
        r_csum     <= r_csum + i_rx_data;
        r_idx      <= 4'd0;
      end
      if (w_loadPay) begin
        r_csum <= r_csum + i_rx_data;
        r_idx  <= r_idx + 4'd1;
      end
    end
  end

  // Payload storage; contents are meaningless after reset, so no reset here.
  always_ff @(posedge i_clk) begin
    if (w_loadPay) begin
      r_buf[r_idx] <= i_rx_data;
    end
  end

  // Registered read port, one cycle of latency from rd_addr.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdData <= 8'd0;
    end else begin
      r_rdData <= r_buf[i_rd_addr];
    end
  end

  // Error and overrun pulses; the error code holds until the next error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frameErr <= 1'b0;
      r_errCode  <= 2'd0;
      r_overrun  <= 1'b0;
    end else begin
      r_frameErr <= w_errPulse;
      r_overrun  <= w_overrunPulse;
      if (w_errPulse) begin
        r_errCode <= w_errCodeNext;
      end
    end
  end

  assign o_frame_valid = (r_state == HOLD);
  assign o_frame_cmd   = r_frameCmd;
  assign o_frame_len   = r_frameLen;
  assign o_rd_data     = r_rdData;
  assign o_frame_err   = r_frameErr;
  assign o_err_code    = r_errCode;
  assign o_overrun     = r_overrun;

endmodule
